// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module      : mdu_ctrl_pkg
// Description : Shared MD op codes, counter width and op-class helpers.
//               MDU_MADD_EN adds the MADD/MADDU accumulate ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_md_calc.sv
// ============================================================================
// Module      : md_calc
// Description : Combinational multiply/divide datapath producing {hi,lo}.
//               MDU_MADD_EN enables the MADD/MADDU accumulate results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_mdOp,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_pending,
    output logic        o_div0
);

    logic signed [63:0] w_sa64;
    logic signed [63:0] w_sb64;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic               w_b_zero;
    logic               w_s_ovf;
    logic        [31:0] w_sdivisor;
    logic        [31:0] w_udivisor;
    logic        [31:0] w_squo;
    logic        [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;

    assign w_sa64  = {{32{i_srcA[31]}}, i_srcA};
    assign w_sb64  = {{32{i_srcB[31]}}, i_srcB};
    assign w_sprod = w_sa64 * w_sb64;
    assign w_uprod = {32'd0, i_srcA} * {32'd0, i_srcB};

    // Dividing by 1 yields the overflow answer (LO=dividend, HI=0) and keeps
    // the divider defined for a zero divisor, whose result is discarded anyway.
    assign w_b_zero   = (i_srcB == 32'd0);
    assign w_s_ovf    = (i_srcA == 32'h8000_0000) && (i_srcB == 32'hFFFF_FFFF);
    assign w_sdivisor = (w_b_zero || w_s_ovf) ? 32'd1 : i_srcB;
    assign w_udivisor = w_b_zero ? 32'd1 : i_srcB;

    assign w_squo = $signed(i_srcA) / $signed(w_sdivisor);
    assign w_srem = $signed(i_srcA) % $signed(w_sdivisor);
    assign w_uquo = i_srcA / w_udivisor;
    assign w_urem = i_srcA % w_udivisor;

`ifndef MDU_MADD_EN
    logic w_unused_hilo;
    assign w_unused_hilo = ^{i_hi, i_lo};
`endif

    always_comb begin
        o_pending = 64'd0;
        o_div0    = 1'b0;
        case (i_mdOp)
            MD_MULT:  o_pending = w_sprod;
            MD_MULTU: o_pending = w_uprod;
            MD_DIV: begin
                o_pending = {w_srem, w_squo};
                o_div0    = w_b_zero;
            end
            MD_DIVU: begin
                o_pending = {w_urem, w_uquo};
                o_div0    = w_b_zero;
            end
`ifdef MDU_MADD_EN
            MD_MADD:  o_pending = {i_hi, i_lo} + w_sprod;
            MD_MADDU: o_pending = {i_hi, i_lo} + w_uprod;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle MD unit sequencer with HI/LO register file.
//               Define MDU_MADD_EN to enable MADD/MADDU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdOp,
    input  logic        start,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdRes
);

    localparam logic [CNT_W-1:0] c_MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mdu_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [63:0]      r_pend, w_pend_nxt;
    logic             r_pend_dz, w_pend_dz_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [63:0]      w_calc;
    logic             w_div0;

    md_calc u_md_calc (
        .i_mdOp    (mdOp),
        .i_srcA    (srcA),
        .i_srcB    (srcB),
        .i_hi      (r_hi),
        .i_lo      (r_lo),
        .o_pending (w_calc),
        .o_div0    (w_div0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pend    <= 64'd0;
            r_pend_dz <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_dz <= w_pend_dz_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_pend_dz_nxt = r_pend_dz;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(mdOp)) begin
                        w_pend_nxt    = w_calc;
                        w_pend_dz_nxt = 1'b0;
                        w_cnt_nxt     = c_MULT_LAT;
                        w_state_nxt   = ST_RUN;
                    end else if (is_div_op(mdOp)) begin
                        w_pend_nxt    = w_calc;
                        w_pend_dz_nxt = w_div0;
                        w_cnt_nxt     = c_DIV_LAT;
                        w_state_nxt   = ST_RUN;
                    end else if (mdOp == MD_MTHI) begin
                        w_hi_nxt = srcA;
                    end else if (mdOp == MD_MTLO) begin
                        w_lo_nxt = srcA;
                    end
                end
            end
            ST_RUN: begin
                // A start here is a protocol violation and is deliberately dropped.
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_pend_dz) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        mdRes = 32'd0;
        if (mdOp == MD_MFHI) begin
            mdRes = r_hi;
        end else if (mdOp == MD_MFLO) begin
            mdRes = r_lo;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Directed scoreboard bench for mdu_ctrl (MDU_MADD_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdOp  = MD_NONE;
    logic [31:0] srcA  = 32'd0;
    logic [31:0] srcB  = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdRes;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdOp  (mdOp),
        .start (start),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .mdRes (mdRes)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ends on the falling edge right after the start edge (busy cycle 1).
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        @(negedge clk);
        mdOp = op; srcA = a; srcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdOp = MD_NONE;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        mdOp = op; srcA = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdOp = MD_NONE;
    endtask

    task automatic wait_done(input string tag, input int n);
        logic [63:0] e;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_sb: observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, e);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mdres", {32'd0, mdRes}, 64'd0);
        rst_n = 1'b1;

        launch(MD_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        wait_done("mult", 5);
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b1);
        wait_done("multu", 5);
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        wait_done("div", 10);
        launch(MD_DIVU, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        wait_done("divu_by0", 10);
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        wait_done("div_ovf", 10);

        // Starts during a busy window must be ignored.
        launch(MD_MULT, 32'd3, 32'd4, 64'd12, 1'b1);
        chk("ign_c1_busy", {63'd0, busy}, 64'd1);
        mdOp = MD_DIV; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(negedge clk);
        chk("ign_c2_busy", {63'd0, busy}, 64'd1);
        mdOp = MD_MTHI; srcA = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        chk("ign_c3_busy", {63'd0, busy}, 64'd1);
        chk("ign_mthi_hi", {32'd0, hi}, 64'd0);
        start = 1'b0; mdOp = MD_NONE;
        @(negedge clk);
        wait_done("mult_ign", 2);

        mt(MD_MTLO, 32'h1234);
        chk("mtlo_lo", {32'd0, lo}, 64'h1234);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        mdOp = MD_MFLO; #1;
        chk("mflo_res", {32'd0, mdRes}, 64'h1234);
        mdOp = MD_MFHI; #1;
        chk("mfhi_res", {32'd0, mdRes}, 64'd0);
        mdOp = MD_NONE; #1;
        chk("none_res", {32'd0, mdRes}, 64'd0);

        // Asynchronous reset in the middle of a divide.
        mt(MD_MTHI, 32'd5);
        mt(MD_MTLO, 32'd5);
        chk("pre_rst_hilo", {hi, lo}, 64'h0000_0005_0000_0005);
        launch(MD_DIV, 32'd100, 32'd7, 64'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            chk("rst_run_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        chk("rst_c4_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_hilo", {hi, lo}, 64'd0);
        launch(MD_MULT, 32'd6, 32'd7, 64'd42, 1'b1);
        wait_done("mult_after_rst", 5);

        // Ops that must not launch anything.
        launch(MD_MFHI, 32'd9, 32'd9, 64'd0, 1'b0);
        chk("start_mfhi_busy", {63'd0, busy}, 64'd0);
        launch(4'd15, 32'd9, 32'd9, 64'd0, 1'b0);
        chk("start_undef_busy", {63'd0, busy}, 64'd0);
        chk("start_undef_hilo", {hi, lo}, 64'd42);

`ifdef MDU_MADD_EN
        mt(MD_MTHI, 32'd0);
        mt(MD_MTLO, 32'hFFFF_FFFF);
        launch(MD_MADDU, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 1'b1);
        wait_done("maddu", 5);
        launch(MD_MADD, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b1);
        wait_done("madd", 5);
`else
        launch(MD_MADD, 32'd1, 32'd1, 64'd0, 1'b0);
        chk("madd_off_busy", {63'd0, busy}, 64'd0);
        launch(MD_MADDU, 32'd1, 32'd1, 64'd0, 1'b0);
        chk("maddu_off_busy", {63'd0, busy}, 64'd0);
        chk("madd_off_hilo", {hi, lo}, 64'd42);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller and HI/LO register file, placed in the E stage beside the ALU.
- Accepts one MD operation per start pulse and models fixed multiply/divide latency with a down-counter.
- Raises busy so the hazard unit can stall MD-dependent instructions in D.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mdOp  input  4  operation code, `MD_* encoding.
- start  input  1  launch mdOp this cycle; meaningful only for MULT/MULTU/DIV/DIVU/MTHI/MTLO (and MADD/MADDU).
- srcA  input  32  operand A (rs); MTHI/MTLO data.
- srcB  input  32  operand B (rt).
- busy  output  1  unit is computing; registered.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- mdRes  output  32  combinational read data: hi if mdOp==MFHI, lo if mdOp==MFLO, else 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - hi=0, lo=0, busy=0, counter=0, pending result cleared.
  - Asserting reset mid-operation aborts the operation; HI/LO are not updated.
- States: IDLE (counter==0) and RUN (counter!=0). busy = (counter != 0), driven from a register.
- IDLE, start=1, mul op:
  - On the edge, capture the 64-bit result in pending{hi,lo}.
  - counter <= MULT_CYCLES (DIV_CYCLES for div ops).
- RUN:
  - counter decrements on each edge.
  - On the edge where the counter goes 1 to 0, {hi,lo} <= pending and busy drops.
  - busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the first cycle busy=0.
- MTHI/MTLO with start in IDLE: hi (or lo) <= srcA on the same edge. busy is not asserted.
- start while busy is a protocol violation and is ignored: no state change. The hazard unit must stall so this cannot happen.
- MFHI/MFLO need no start. While busy, mdRes returns the old HI/LO; the hazard unit must stall on busy||start.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits.
  - MULTU: unsigned 32x32 to 64 bits.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero: still occupies DIV_CYCLES; HI/LO keep their old values at completion.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- start with mdOp NONE, MFHI, MFLO, or an undefined code: ignored.

Optional Feature:
- MDU_MADD_EN defined:
  - Adds MADD (signed) and MADDU (unsigned).
  - pending = {hi,lo} + product, computed with 64-bit wraparound from the HI/LO values at the start edge.
  - Latency is MULT_CYCLES.
- Undefined: codes 9/10 are treated as undefined and ignored.

Decomposition:
- Shared definitions file: add MD op codes
  - `MD_NONE 0, `MD_MULT 1, `MD_MULTU 2, `MD_DIV 3, `MD_DIVU 4,
  - `MD_MFHI 5, `MD_MFLO 6, `MD_MTHI 7, `MD_MTLO 8, `MD_MADD 9, `MD_MADDU 10,
  - plus a counter width constant (4 bits).
- One sub-module, md_calc: purely combinational; inputs mdOp, srcA, srcB, hi, lo; output the 64-bit pending result and a div-by-zero flag. mdu_ctrl holds the counter, pending register and HI/LO.

Test Plan:
- Signed multiply: MULT srcA=0xFFFFFFFF srcB=2, start at cycle 0 -> busy=1 during cycles 1..5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- Unsigned multiply: MULTU with the same operands -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV srcA=0xFFFFFFF9 (-7) srcB=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with DIVU 7/0 -> after 10 cycles hi/lo unchanged.
- Busy/MT handling: during a MULT busy window, pulse start with DIV and with MTHI -> both ignored; counter and pending unaffected. Afterwards MTLO srcA=0x1234 -> lo=0x1234 next cycle; mdOp=MFLO -> mdRes=0x1234 combinationally.
- Reset mid-operation: DIV started with hi=lo=0x5 previously; assert rst_n=0 at busy cycle 4 (asynchronously, between edges) -> busy=0, hi=lo=0 immediately; after release, a new MULT works normally.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU srcA=1 srcB=1 -> after 5 busy cycles hi=1, lo=0.
